loop_reg_bank: RTL and testbench
================================

# loop_reg_bank

Parametrised CPU register bank for loop-style example datapaths: configurable numbers of RW config words, sticky W1C error words, RO status words and wide event counters. It sits between the shell's CPU register bus and the datapath, and generalises the fixed-count loop register file. It adds a read-valid handshake, wide counters with coherent two-word reads, saturate/wrap mode and per-counter clear.

## Interface
- A_WTH, 24, CPU address width (≥24)
- D_WTH, 32, CPU data width (fixed 32)
- CM_ID, 12'h001, module ID compared against cpu_addr[23:12]
- CFG_NUM, 3, config words (1..32)
- CFG_INIT, {CFG_NUM{32'h0}}, packed reset values, word k at [32k+31:32k]
- ERR_NUM, 2, error words (1..32)
- STA_NUM, 2, status words (1..32)
- CNT_NUM, 5, counters (1..32)
- CNT_WTH, 48, counter width (33..64)
- CNT_SAT, 1, 1 = saturate at all-ones, 0 = wrap to 0
- clk_sys  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cpu_addr  in  A_WTH  register word address
- cpu_data_in  in  32  write data
- cpu_wr  in  1  single-cycle write strobe
- cpu_rd  in  1  single-cycle read strobe
- cpu_data_out_pf  out  32  read data, valid with cpu_rd_vld, else 0
- cpu_rd_vld  out  1  read data valid pulse
- cnt_reg_clr  in  1  global clear of all counters
- cfg_out  out  32*CFG_NUM  config word contents
- err_in  in  32*ERR_NUM  error event bits, level-sampled each cycle
- err_any  out  1  OR of all sticky error bits, registered
- sta_in  in  32*STA_NUM  live status
- cnt_inc  in  CNT_NUM  per-counter increment enables

## Operation
- Hit: cpu_addr[23:12]==CM_ID and cpu_addr[11:9]==0. Region = cpu_addr[8:7]: 0 cfg, 1 err, 2 sta, 3 cnt. Index i = cpu_addr[6:0].
- cfg: a write with i<CFG_NUM loads the word. Reads return the word. i≥CFG_NUM reads 0 and writes are ignored.
- err: bit sets when err_in bit is 1. A write clears the bits where cpu_data_in=1 (W1C). Same-cycle set and clear on a bit: set wins.
- sta: reads return sta_in[i] sampled at the read-stage-1 edge.
- cnt: counter k maps to i=2k (low 32 bits) and i=2k+1 (high bits [CNT_WTH-1:32], zero-extended). Any write to 2k or 2k+1 clears counter k.
- Counter update priority: cnt_reg_clr or per-counter clear, then 0. Otherwise cnt_inc increments. At all-ones with CNT_SAT=1 the counter holds; with CNT_SAT=0 it wraps to 0. Clear with simultaneous inc yields 0.
- Coherent read: a read of word 2k latches counter k's high bits into a shadow register and records tag=k. A read of 2k+1 returns the shadow if tag==k, else the live high bits. The shadow and tag are held until the next low read. A global clear does not alter the shadow.
- Misses and out-of-range indices produce no cpu_rd_vld and leave all state untouched.

## Timing
- Reset values: cfg_out=CFG_INIT, all err bits 0, all counters 0, shadow 0, tag 0, cpu_data_out_pf 0, cpu_rd_vld 0, err_any 0.
- Read latency is 2. With cpu_rd at cycle T, stage 1 registers region, index and hit, and samples the selected source. At T+2, cpu_rd_vld=1 for one cycle with the data.
- Reads are fully pipelined: one per cycle, with no back-pressure.
- cpu_rd and cpu_wr on the same cycle and address: the read returns the pre-write value.
- Writes: cfg_out, err clear and counter clear take effect at the edge after cpu_wr.
- err_any lags the sticky bits by 1 cycle.
- Counter visible value: an increment at cycle T is readable by a cpu_rd issued at T+1.
- Asynchronous reset mid-read kills in-flight stage-1 and stage-2 valids; no cpu_rd_vld is emitted for those reads.

## Structure
- Package loop_reg_pkg: region codes (CFG=2'd0, ERR=2'd1, STA=2'd2, CNT=2'd3), RD_LAT=2, index width 7.
- Sub-module loop_reg_cnt: one CNT_WTH counter with clr, inc and SAT parameter. It is instantiated CNT_NUM times via generate.
- cfg, err and sta arrays are generate loops in the top. The read mux is indexed, not a case list.

## Test plan
- Reset with CFG_INIT word0=32'h190: read cfg0 -> cpu_rd_vld at T+2, data 32'h190. Read cfg index 5 (CFG_NUM=3) -> no cpu_rd_vld.
- Pulse err_in[0] bits 3 and 0: err word0 reads 32'h9 and err_any=1. Write 32'h1 -> reads 32'h8. W1C on bit 3 in the same cycle as err_in bit 3 -> bit stays 1.
- Preload counter 2 to 48'h0000_FFFF_FFFF, then one cnt_inc. Read index 4 -> 32'h0. Pulse 3 more incs, then read index 5 -> 32'h1 (shadow). Reading 5 after a low read of counter 1 -> live high.
- CNT_SAT=1: counter at all-ones plus inc -> holds all-ones. CNT_SAT=0: wraps to 0.
- cnt_reg_clr coincident with cnt_inc -> counter 0. Write to index 6 -> only counter 3 cleared.
- Back-to-back reads of 4 addresses -> 4 consecutive cpu_rd_vld pulses in order. Assert rst between T and T+2 -> no cpu_rd_vld and all outputs at reset values.

Source files
------------

// File: rtl/loop_reg_pkg.sv
// Shared encodings for the loop register bank: address regions, read pipeline depth, word-index width.
package loop_reg_pkg;
    typedef enum logic [1:0] {
        CFG = 2'd0,
        ERR = 2'd1,
        STA = 2'd2,
        CNT = 2'd3
    } region_e;

    localparam int RD_LAT = 2;
    localparam int IDX_W  = 7;
    localparam int IDX_N  = 1 << IDX_W;
endpackage

// File: rtl/loop_reg_cnt.sv
// One wide event counter; clear beats increment, and at all-ones it holds (SAT=1) or wraps to zero.
// Value updates at the edge after clr_i/inc_i.
module loop_reg_cnt #(
    parameter int WTH = 48,
    parameter bit SAT = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           inc_i,
    output logic [WTH-1:0] cnt_o
);
    logic [WTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            if (&cnt_q) begin
                cnt_d = SAT ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + WTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/loop_reg_bank.sv
// CPU register bank: RW config, sticky W1C error, RO status words and wide counters with coherent hi/lo reads.
// Reads return RD_LAT cycles after cpu_rd, fully pipelined; writes land at the next edge.
module loop_reg_bank
    import loop_reg_pkg::*;
#(
    parameter int                    A_WTH    = 24,
    parameter int                    D_WTH    = 32,
    parameter logic [11:0]           CM_ID    = 12'h001,
    parameter int                    CFG_NUM  = 3,
    parameter logic [32*CFG_NUM-1:0] CFG_INIT = '0,
    parameter int                    ERR_NUM  = 2,
    parameter int                    STA_NUM  = 2,
    parameter int                    CNT_NUM  = 5,
    parameter int                    CNT_WTH  = 48,
    parameter bit                    CNT_SAT  = 1'b1
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic [A_WTH-1:0]        cpu_addr,
    input  logic [D_WTH-1:0]        cpu_data_in,
    input  logic                    cpu_wr,
    input  logic                    cpu_rd,
    output logic [D_WTH-1:0]        cpu_data_out_pf,
    output logic                    cpu_rd_vld,
    input  logic                    cnt_reg_clr,
    output logic [32*CFG_NUM-1:0]   cfg_out,
    input  logic [32*ERR_NUM-1:0]   err_in,
    output logic                    err_any,
    input  logic [32*STA_NUM-1:0]   sta_in,
    input  logic [CNT_NUM-1:0]      cnt_inc
);
    logic             hit, in_rng, rd_ok, wr_ok;
    region_e          rgn;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-2:0] cidx;

    assign hit   = (cpu_addr[23:12] == CM_ID) && (cpu_addr[11:9] == 3'd0);
    assign rgn   = region_e'(cpu_addr[8:7]);
    assign idx   = cpu_addr[IDX_W-1:0];
    assign cidx  = idx[IDX_W-1:1];
    assign rd_ok = cpu_rd && hit && in_rng;
    assign wr_ok = cpu_wr && hit && in_rng;

    always_comb begin
        in_rng = 1'b0;
        case (rgn)
            CFG: in_rng = int'(idx) < CFG_NUM;
            ERR: in_rng = int'(idx) < ERR_NUM;
            STA: in_rng = int'(idx) < STA_NUM;
            CNT: in_rng = int'(idx) < 2 * CNT_NUM;
        endcase
    end

    // Every source is padded to the full index space so the read mux is a plain array index.
    logic [31:0]        cfg_rd [IDX_N];
    logic [31:0]        err_rd [IDX_N];
    logic [31:0]        sta_rd [IDX_N];
    logic [31:0]        cnt_lo [IDX_N/2];
    logic [31:0]        cnt_hi [IDX_N/2];
    logic [ERR_NUM-1:0] err_nz;

    for (genvar k = 0; k < IDX_N; k++) begin : g_cfg
        if (k < CFG_NUM) begin : g_w
            logic [31:0] word_q;
            always_ff @(posedge clk_sys or posedge rst) begin
                if (rst)                                        word_q <= CFG_INIT[32*k +: 32];
                else if (wr_ok && rgn == CFG && int'(idx) == k) word_q <= cpu_data_in;
            end
            assign cfg_rd[k]            = word_q;
            assign cfg_out[32*k +: 32]  = word_q;
        end else begin : g_pad
            assign cfg_rd[k] = '0;
        end
    end

    for (genvar k = 0; k < IDX_N; k++) begin : g_err
        if (k < ERR_NUM) begin : g_w
            logic [31:0] word_q, clr;
            // A set in the same cycle as a W1C clear survives.
            assign clr = (wr_ok && rgn == ERR && int'(idx) == k) ? cpu_data_in : '0;
            always_ff @(posedge clk_sys or posedge rst) begin
                if (rst) word_q <= '0;
                else     word_q <= (word_q & ~clr) | err_in[32*k +: 32];
            end
            assign err_rd[k] = word_q;
            assign err_nz[k] = |word_q;
        end else begin : g_pad
            assign err_rd[k] = '0;
        end
    end

    for (genvar k = 0; k < IDX_N; k++) begin : g_sta
        if (k < STA_NUM) begin : g_w
            assign sta_rd[k] = sta_in[32*k +: 32];
        end else begin : g_pad
            assign sta_rd[k] = '0;
        end
    end

    for (genvar k = 0; k < IDX_N/2; k++) begin : g_cnt
        if (k < CNT_NUM) begin : g_c
            logic [CNT_WTH-1:0] cnt_v;
            loop_reg_cnt #(.WTH(CNT_WTH), .SAT(CNT_SAT)) u_cnt (
                .clk_i (clk_sys),
                .rst_i (rst),
                .clr_i (cnt_reg_clr || (wr_ok && rgn == CNT && int'(cidx) == k)),
                .inc_i (cnt_inc[k]),
                .cnt_o (cnt_v)
            );
            assign cnt_lo[k] = cnt_v[31:0];
            assign cnt_hi[k] = 32'(cnt_v[CNT_WTH-1:32]);
        end else begin : g_pad
            assign cnt_lo[k] = '0;
            assign cnt_hi[k] = '0;
        end
    end

    // The low-word read snapshots the high half so a following high read is coherent.
    logic [31:0]      shadow_q;
    logic [IDX_W-2:0] tag_q;
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            tag_q    <= '0;
        end else if (rd_ok && rgn == CNT && !idx[0]) begin
            shadow_q <= cnt_hi[cidx];
            tag_q    <= cidx;
        end
    end

    logic [31:0] rd_dat;
    always_comb begin
        rd_dat = '0;
        case (rgn)
            CFG: rd_dat = cfg_rd[idx];
            ERR: rd_dat = err_rd[idx];
            STA: rd_dat = sta_rd[idx];
            CNT: rd_dat = !idx[0]         ? cnt_lo[cidx] :
                          (tag_q == cidx) ? shadow_q     : cnt_hi[cidx];
        endcase
    end

    logic [RD_LAT-1:0] vld_q;
    logic [31:0]       dat_q [RD_LAT];
    logic              err_any_q;
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            err_any_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q     <= {vld_q[RD_LAT-2:0], rd_ok};
            dat_q[0]  <= rd_ok ? rd_dat : '0;
            for (int i = 1; i < RD_LAT; i++) dat_q[i] <= dat_q[i-1];
            err_any_q <= |err_nz;
        end
    end

    assign cpu_rd_vld      = vld_q[RD_LAT-1];
    assign cpu_data_out_pf = dat_q[RD_LAT-1];
    assign err_any         = err_any_q;
endmodule

// File: tb/tb_loop_reg_bank.sv
// Bench for loop_reg_bank: directed literal checks plus randomized traffic against a behavioural model.
module tb_loop_reg_bank;
    localparam int          CM_ID    = 1;
    localparam int          CFG_NUM  = 3;
    localparam int          ERR_NUM  = 2;
    localparam int          STA_NUM  = 2;
    localparam int          CNT_NUM  = 5;
    localparam int          CNT_WTH  = 48;
    localparam bit          CNT_SAT  = 1'b1;
    localparam logic [95:0] CFG_INIT = 96'hA5A5_0002_0000_0011_0000_0190;
    localparam logic [63:0] MAXC     = (64'd1 << CNT_WTH) - 64'd1;

    logic         clk_sys = 1'b0;
    logic         rst = 1'b1;
    logic [23:0]  cpu_addr = '0;
    logic [31:0]  cpu_data_in = '0;
    logic         cpu_wr = 1'b0, cpu_rd = 1'b0;
    logic [31:0]  cpu_data_out_pf;
    logic         cpu_rd_vld;
    logic         cnt_reg_clr = 1'b0;
    logic [95:0]  cfg_out;
    logic [63:0]  err_in = '0;
    logic         err_any;
    logic [63:0]  sta_in = '0;
    logic [4:0]   cnt_inc = '0;
    logic         sc_clr = 1'b0, sc_inc = 1'b0;
    logic [3:0]   sc_sat_v, sc_wrap_v;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 clk_sys = ~clk_sys;

    loop_reg_bank #(
        .A_WTH(24), .D_WTH(32), .CM_ID(12'h001), .CFG_NUM(CFG_NUM), .CFG_INIT(CFG_INIT),
        .ERR_NUM(ERR_NUM), .STA_NUM(STA_NUM), .CNT_NUM(CNT_NUM), .CNT_WTH(CNT_WTH), .CNT_SAT(CNT_SAT)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_data_out_pf(cpu_data_out_pf), .cpu_rd_vld(cpu_rd_vld),
        .cnt_reg_clr(cnt_reg_clr), .cfg_out(cfg_out), .err_in(err_in), .err_any(err_any),
        .sta_in(sta_in), .cnt_inc(cnt_inc)
    );

    loop_reg_cnt #(.WTH(4), .SAT(1'b1)) u_sc_sat (
        .clk_i(clk_sys), .rst_i(rst), .clr_i(sc_clr), .inc_i(sc_inc), .cnt_o(sc_sat_v));
    loop_reg_cnt #(.WTH(4), .SAT(1'b0)) u_sc_wrap (
        .clk_i(clk_sys), .rst_i(rst), .clr_i(sc_clr), .inc_i(sc_inc), .cnt_o(sc_wrap_v));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [23:0] ad(input int rg, input int ix);
        logic [1:0] r;
        logic [6:0] i;
        r = rg[1:0];
        i = ix[6:0];
        return {12'h001, 3'b000, r, i};
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mcfg [CFG_NUM];
    logic [31:0] merr [ERR_NUM];
    logic [63:0] mcnt [CNT_NUM];
    logic [31:0] msh;
    int          mtag;
    bit          e1v, e2v, m_any;
    logic [31:0] e1d, e2d;

    always @(posedge clk_sys or posedge rst) begin : model
        int a, rg, ix, lim, clr_k;
        bit ok;
        logic [31:0] rv, wclr;
        if (rst) begin
            for (int w = 0; w < CFG_NUM; w++) mcfg[w] = CFG_INIT[32*w +: 32];
            for (int w = 0; w < ERR_NUM; w++) merr[w] = '0;
            for (int c = 0; c < CNT_NUM; c++) mcnt[c] = '0;
            msh = '0; mtag = 0; e1v = 0; e2v = 0; e1d = '0; e2d = '0; m_any = 0;
        end else begin
            a   = int'(cpu_addr);
            rg  = (a >> 7) & 3;
            ix  = a & 127;
            lim = (rg == 0) ? CFG_NUM : (rg == 1) ? ERR_NUM : (rg == 2) ? STA_NUM : 2 * CNT_NUM;
            ok  = (((a >> 12) & 'hFFF) == CM_ID) && (((a >> 9) & 7) == 0) && (ix < lim);
            rv  = '0;
            if (ok) begin
                case (rg)
                    0: rv = mcfg[ix];
                    1: rv = merr[ix];
                    2: rv = sta_in[32*ix +: 32];
                    default: begin
                        if (ix % 2 == 0)       rv = mcnt[ix/2][31:0];
                        else if (mtag == ix/2) rv = msh;
                        else                   rv = mcnt[ix/2][63:32];
                    end
                endcase
            end
            if (cpu_rd && ok && rg == 3 && ix % 2 == 0) begin
                msh  = mcnt[ix/2][63:32];
                mtag = ix / 2;
            end
            e2v = e1v; e2d = e1d;
            e1v = cpu_rd && ok;
            e1d = e1v ? rv : '0;
            m_any = 0;
            for (int w = 0; w < ERR_NUM; w++) if (merr[w] != 0) m_any = 1;
            clr_k = -1;
            if (cpu_wr && ok && rg == 0) mcfg[ix] = cpu_data_in;
            if (cpu_wr && ok && rg == 3) clr_k = ix / 2;
            for (int w = 0; w < ERR_NUM; w++) begin
                wclr = (cpu_wr && ok && rg == 1 && ix == w) ? cpu_data_in : '0;
                merr[w] = (merr[w] & ~wclr) | err_in[32*w +: 32];
            end
            for (int c = 0; c < CNT_NUM; c++) begin
                if (cnt_reg_clr || clr_k == c) mcnt[c] = '0;
                else if (cnt_inc[c])           mcnt[c] = (mcnt[c] == MAXC) ? (CNT_SAT ? MAXC : 64'd0) : mcnt[c] + 64'd1;
            end
        end
    end

    initial begin : compare
        wait (started);
        forever begin
            @(posedge clk_sys);
            #2;
            chk("rd_vld", cpu_rd_vld, e2v);
            chk("rd_dat", cpu_data_out_pf, e2v ? e2d : 32'h0);
            chk("err_any", err_any, m_any);
            for (int w = 0; w < CFG_NUM; w++) chk("cfg_out", cfg_out[32*w +: 32], mcfg[w]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic rd_chk(input logic [23:0] a, input logic [31:0] exp, input string nm);
        cpu_addr = a; cpu_rd = 1'b1;
        @(negedge clk_sys);
        cpu_rd = 1'b0;
        @(negedge clk_sys);
        chk({nm, "_vld"}, cpu_rd_vld, 1'b1);
        chk(nm, cpu_data_out_pf, exp);
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        cpu_addr = a; cpu_data_in = d; cpu_wr = 1'b1;
        @(negedge clk_sys);
        cpu_wr = 1'b0;
    endtask

    task automatic inc_n(input logic [4:0] m, input int n);
        cnt_inc = m;
        repeat (n) @(negedge clk_sys);
        cnt_inc = '0;
    endtask

    logic [23:0] b2b_a [4];
    logic [31:0] b2b_d [4];

    initial begin : stim
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        started = 1'b1;
        chk("rst_vld", cpu_rd_vld, 1'b0);
        chk("rst_dat", cpu_data_out_pf, 32'h0);
        chk("rst_err_any", err_any, 1'b0);
        chk("rst_cfg", cfg_out, CFG_INIT);

        rd_chk(ad(0, 0), 32'h0000_0190, "cfg0");
        cpu_addr = ad(0, 5); cpu_rd = 1'b1;
        @(negedge clk_sys); cpu_rd = 1'b0;
        @(negedge clk_sys);
        chk("cfg5_no_vld", cpu_rd_vld, 1'b0);

        sta_in = 64'h0BAD_F00D_1234_5678;
        b2b_a[0] = ad(0, 0); b2b_d[0] = 32'h0000_0190;
        b2b_a[1] = ad(0, 1); b2b_d[1] = 32'h0000_0011;
        b2b_a[2] = ad(0, 2); b2b_d[2] = 32'hA5A5_0002;
        b2b_a[3] = ad(2, 1); b2b_d[3] = 32'h0BAD_F00D;
        for (int j = 0; j < 7; j++) begin
            if (j >= 2 && j < 6) begin
                chk("b2b_vld", cpu_rd_vld, 1'b1);
                chk("b2b_dat", cpu_data_out_pf, b2b_d[j-2]);
            end
            if (j == 6) chk("b2b_end_vld", cpu_rd_vld, 1'b0);
            cpu_rd = (j < 4);
            if (j < 4) cpu_addr = b2b_a[j];
            @(negedge clk_sys);
        end
        cpu_rd = 1'b0;

        err_in = 64'h9;
        @(negedge clk_sys); err_in = '0;
        @(negedge clk_sys);
        chk("err_any_set", err_any, 1'b1);
        rd_chk(ad(1, 0), 32'h9, "err0_set");
        wr(ad(1, 0), 32'h1);
        rd_chk(ad(1, 0), 32'h8, "err0_w1c");
        err_in = 64'h8;
        wr(ad(1, 0), 32'h8);
        err_in = '0;
        rd_chk(ad(1, 0), 32'h8, "err0_set_wins");
        wr(ad(1, 0), 32'h8);
        rd_chk(ad(1, 0), 32'h0, "err0_clear");
        chk("err_any_clr", err_any, 1'b0);

        force dut.g_cnt[2].g_c.u_cnt.cnt_q = 48'h0000_FFFF_FFFF;
        mcnt[2] = 64'h0000_FFFF_FFFF;
        #1 release dut.g_cnt[2].g_c.u_cnt.cnt_q;
        @(negedge clk_sys);
        rd_chk(ad(3, 4), 32'hFFFF_FFFF, "c2_lo_pre");
        inc_n(5'b00100, 1);
        rd_chk(ad(3, 5), 32'h0, "c2_hi_shadow_old");
        rd_chk(ad(3, 4), 32'h0, "c2_lo_carry");
        inc_n(5'b00100, 3);
        rd_chk(ad(3, 5), 32'h1, "c2_hi_shadow");
        rd_chk(ad(3, 2), 32'h0, "c1_lo");
        rd_chk(ad(3, 5), 32'h1, "c2_hi_live");
        rd_chk(ad(3, 4), 32'h3, "c2_lo_live");

        force dut.g_cnt[0].g_c.u_cnt.cnt_q = 48'hFFFF_FFFF_FFFF;
        mcnt[0] = 64'h0000_FFFF_FFFF_FFFF;
        #1 release dut.g_cnt[0].g_c.u_cnt.cnt_q;
        @(negedge clk_sys);
        inc_n(5'b00001, 1);
        rd_chk(ad(3, 0), 32'hFFFF_FFFF, "c0_sat_lo");
        rd_chk(ad(3, 1), 32'h0000_FFFF, "c0_sat_hi");

        cnt_reg_clr = 1'b1; cnt_inc = 5'h1F;
        @(negedge clk_sys);
        cnt_reg_clr = 1'b0; cnt_inc = '0;
        rd_chk(ad(3, 4), 32'h0, "clr_c2");
        rd_chk(ad(3, 0), 32'h0, "clr_c0");
        inc_n(5'h1F, 3);
        wr(ad(3, 6), 32'h0);
        rd_chk(ad(3, 6), 32'h0, "wclr_c3");
        rd_chk(ad(3, 2), 32'h3, "keep_c1");
        rd_chk(ad(3, 8), 32'h3, "keep_c4");

        wr(ad(0, 1), 32'hDEAD_BEEF);
        wr(ad(0, 5), 32'h1111_1111);
        rd_chk(ad(0, 1), 32'hDEAD_BEEF, "cfg1_wr");
        cpu_addr = ad(0, 1); cpu_data_in = 32'h5555_AAAA; cpu_wr = 1'b1; cpu_rd = 1'b1;
        @(negedge clk_sys); cpu_wr = 1'b0; cpu_rd = 1'b0;
        @(negedge clk_sys);
        chk("rdwr_pre_value", cpu_data_out_pf, 32'hDEAD_BEEF);

        cpu_addr = ad(0, 0); cpu_rd = 1'b1;
        @(negedge clk_sys);
        cpu_rd = 1'b0; rst = 1'b1;
        @(negedge clk_sys);
        chk("midrst_vld", cpu_rd_vld, 1'b0);
        chk("midrst_dat", cpu_data_out_pf, 32'h0);
        chk("midrst_cfg", cfg_out, CFG_INIT);
        chk("midrst_err_any", err_any, 1'b0);
        rst = 1'b0;
        @(negedge clk_sys);
        chk("midrst_vld2", cpu_rd_vld, 1'b0);

        sc_inc = 1'b1;
        repeat (15) @(negedge clk_sys);
        chk("sc_sat_15", sc_sat_v, 4'hF);
        chk("sc_wrap_15", sc_wrap_v, 4'hF);
        @(negedge clk_sys);
        chk("sc_sat_hold", sc_sat_v, 4'hF);
        chk("sc_wrap_zero", sc_wrap_v, 4'h0);
        sc_clr = 1'b1;
        @(negedge clk_sys);
        chk("sc_clr_inc", sc_sat_v, 4'h0);
        sc_clr = 1'b0; sc_inc = 1'b0;

        for (int n = 0; n < 1500; n++) begin
            int rg, ix;
            rg = $urandom_range(0, 3);
            ix = $urandom_range(0, 11);
            cpu_addr = ad(rg, ix);
            if ($urandom_range(0, 15) == 0) cpu_addr[23:12] = 12'h002;
            if ($urandom_range(0, 15) == 0) cpu_addr[10] = 1'b1;
            cpu_rd      = 1'($urandom);
            cpu_wr      = ($urandom_range(0, 3) == 0);
            cpu_data_in = $urandom;
            cnt_inc     = 5'($urandom);
            cnt_reg_clr = ($urandom_range(0, 63) == 0);
            sta_in      = {$urandom, $urandom};
            err_in      = '0;
            if ($urandom_range(0, 7) == 0) err_in[$urandom_range(0, 63)] = 1'b1;
            @(negedge clk_sys);
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0; cnt_inc = '0; cnt_reg_clr = 1'b0; err_in = '0;
        repeat (4) @(negedge clk_sys);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
